sync_mod_counter: RTL and testbench

SYNC_MOD_COUNTER -- requirements
Module: sync_mod_counter

---
 rtl/sync_cnt_pkg.sv | 34 +++
 rtl/tff_cell.sv | 18 +
 rtl/sync_mod_counter.sv | 69 ++++++
 tb/tb_sync_mod_counter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sync_cnt_pkg.sv
// Shared definitions for the synchronous modulo counter: direction encoding and
// the per-bit toggle-enable function that drives the toggle cells.
package sync_cnt_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Works on a 32-bit view of the count; the caller keeps only its low WIDTH bits.
    // A bit toggles exactly when the current and next count disagree in that position.
    function automatic logic [31:0] toggle_mask(
        input logic [31:0] cur,
        input logic        clr,
        input logic        load,
        input logic [31:0] ld_val,
        input logic        en,
        input logic        dir,
        input logic [31:0] modulus
    );
        logic [31:0] nxt;
        nxt = cur;
        if (clr) begin
            nxt = '0;
        end else if (load) begin
            nxt = (ld_val < modulus) ? ld_val : modulus - 32'd1;
        end else if (en) begin
            if (dir == DIR_UP)
                nxt = (cur == modulus - 32'd1) ? '0 : cur + 32'd1;
            else
                nxt = (cur == '0) ? modulus - 32'd1 : cur - 32'd1;
        end
        return cur ^ nxt;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single falling-edge toggle flip-flop with asynchronous active-low reset.
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    // NOTE: state registers use non-blocking assignments so every cell samples
    // the same pre-edge toggle enables regardless of evaluation order.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= 1'b0;
        else if (t)
            q <= ~q;
    end

endmodule

// File: rtl/sync_mod_counter.sv
// Synchronous up/down modulo counter built from toggle cells, falling-edge clocked.
// Optional Gray-code output when SYNC_MOD_COUNTER_GRAY_EN is defined.
module sync_mod_counter
    import sync_cnt_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             load_err
`ifdef SYNC_MOD_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] q_gray
`endif
);

    localparam int          MAX_MOD = 1 << WIDTH;
    localparam logic [31:0] MOD32   = 32'(MODULUS);

    if (WIDTH < 1 || WIDTH > 30) begin : g_bad_width
        $error("sync_mod_counter: WIDTH must be in 1..30");
    end
    if (MODULUS < 2 || MODULUS > MAX_MOD) begin : g_bad_modulus
        $error("sync_mod_counter: MODULUS must be in 2..2**WIDTH");
    end

    logic [31:0]      q_ext;
    logic [31:0]      ld_ext;
    logic [WIDTH-1:0] t;

    assign q_ext  = 32'(q);
    assign ld_ext = 32'(load_val);
    assign t      = WIDTH'(toggle_mask(q_ext, clr, load, ld_ext, en, up_dn, MOD32));

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (t[i]),
            .q     (q[i])
        );
    end

    // Terminal count reflects the edge about to happen, so it is gated by the
    // same priority as the count itself.
    assign tc = en && !clr && !load &&
                (((up_dn == DIR_UP) && (q_ext == MOD32 - 32'd1)) ||
                 ((up_dn == DIR_DN) && (q_ext == '0)));

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)
            load_err <= 1'b0;
        else
            load_err <= !clr && load && (ld_ext >= MOD32);
    end

`ifdef SYNC_MOD_COUNTER_GRAY_EN
    assign q_gray = q ^ (q >> 1);
`endif

endmodule

// File: tb/tb_sync_mod_counter.sv
// Randomized and directed bench for sync_mod_counter: a 3-bit/mod-8 and a
// 4-bit/mod-10 instance share controls and are compared against an arithmetic model.
module tb_sync_mod_counter;

    logic       clk = 1'b1;
    logic       rst_n;
    logic       en, up_dn, clr, load;
    logic [2:0] lv_a;
    logic [3:0] lv_b;
    logic [2:0] q_a;
    logic [3:0] q_b;
    logic       tc_a, tc_b, err_a, err_b;
`ifdef SYNC_MOD_COUNTER_GRAY_EN
    logic [2:0] g_a;
    logic [3:0] g_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int  ma, mb;
    bit  ea, eb;

    always #5 clk = ~clk;

    sync_mod_counter #(.WIDTH(3), .MODULUS(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(lv_a), .q(q_a), .tc(tc_a), .load_err(err_a)
`ifdef SYNC_MOD_COUNTER_GRAY_EN
        , .q_gray(g_a)
`endif
    );

    sync_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(lv_b), .q(q_b), .tc(tc_b), .load_err(err_b)
`ifdef SYNC_MOD_COUNTER_GRAY_EN
        , .q_gray(g_b)
`endif
    );

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int model_next(int cur, int m, bit c, bit l, int lv, bit e, bit up);
        if (c) return 0;
        if (l) return (lv < m) ? lv : m - 1;
        if (e) return up ? (cur + 1) % m : (cur + m - 1) % m;
        return cur;
    endfunction

    function automatic bit model_tc(int cur, int m, bit c, bit l, bit e, bit up);
        return e && !c && !l && (up ? (cur == m - 1) : (cur == 0));
    endfunction

    function automatic int gray(int v);
        return v ^ (v >> 1);
    endfunction

    task automatic idle();
        en = 0; up_dn = 1; clr = 0; load = 0; lv_a = '0; lv_b = '0;
    endtask

    // One falling edge: drive at rising edge, check tc, update model, check outputs.
    task automatic step(input bit s_en, input bit s_up, input bit s_clr, input bit s_ld,
                        input int lva, input int lvb);
        int na, nb;
`ifdef SYNC_MOD_COUNTER_GRAY_EN
        int prev_ga;
`endif
        @(posedge clk);
        en = s_en; up_dn = s_up; clr = s_clr; load = s_ld;
        lv_a = 3'(lva); lv_b = 4'(lvb);
        #1;
        check("tc_a", tc_a, model_tc(ma, 8, s_clr, s_ld, s_en, s_up));
        check("tc_b", tc_b, model_tc(mb, 10, s_clr, s_ld, s_en, s_up));
`ifdef SYNC_MOD_COUNTER_GRAY_EN
        prev_ga = g_a;
`endif
        na = model_next(ma, 8, s_clr, s_ld, int'(lv_a), s_en, s_up);
        nb = model_next(mb, 10, s_clr, s_ld, int'(lv_b), s_en, s_up);
        ea = !s_clr && s_ld && (int'(lv_a) >= 8);
        eb = !s_clr && s_ld && (int'(lv_b) >= 10);
        @(negedge clk);
        #1;
        ma = na; mb = nb;
        check("q_a", q_a, ma);
        check("q_b", q_b, mb);
        check("load_err_a", err_a, ea);
        check("load_err_b", err_b, eb);
`ifdef SYNC_MOD_COUNTER_GRAY_EN
        check("gray_a", g_a, gray(ma));
        check("gray_b", g_b, gray(mb));
        if (s_en && !s_clr && !s_ld)
            check("gray_a_onebit", $countones(3'(g_a ^ 3'(prev_ga))), 1);
`endif
    endtask

    // Assert reset between edges with a load and count pending, then release.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        en = 1; load = 1; lv_b = 4'd12; up_dn = 1;
        rst_n = 0;
        #1;
        ma = 0; mb = 0; ea = 0; eb = 0;
        check("rst_q_a", q_a, 0);
        check("rst_q_b", q_b, 0);
        check("rst_err_b", err_b, 0);
        @(negedge clk);
        #1;
        check("rst_hold_q_b", q_b, 0);
        check("rst_hold_err_b", err_b, 0);
        @(posedge clk);
        idle();
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 0;
        ma = 0; mb = 0; ea = 0; eb = 0;
        #3;
        check("reset_q_a", q_a, 0);
        check("reset_q_b", q_b, 0);
        check("reset_err_a", err_a, 0);
        check("reset_err_b", err_b, 0);
        @(posedge clk);
        @(posedge clk);
        rst_n = 1;

        // Up count through wrap: A shows 1..7,0,1 with tc only at 7.
        for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 0, 0);

        // Down from reset: B shows 9..0,9 with tc only at 0.
        mid_reset();
        for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 0, 0);

        // Out-of-range then in-range load; hold to confirm load_err clears.
        step(0, 1, 0, 1, 5, 12);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 3, 5);
        step(0, 1, 0, 0, 0, 0);

        // clr wins over an out-of-range load and enable at q=6.
        step(0, 1, 0, 1, 6, 6);
        step(1, 1, 1, 1, 7, 12);

        // Direction change takes effect on the very next edge.
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);

        // Reset mid-count at q_b=5, then first up edge gives 1.
        step(0, 1, 0, 1, 5, 5);
        mid_reset();
        step(1, 1, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 8,
                 1'($urandom),
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 15)));
            if ($urandom_range(0, 99) == 0) mid_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
